pipo_shift_reg: RTL and testbench

Parametrised successor to the team's 8-bit parallel-in/parallel-out register. It keeps the synchronous reset and parallel-load behaviour. It adds a multi-cycle shift engine with four modes, a programmable shift count, and a start/busy/done handshake. It is intended as the accumulator/multiplier register in the Booth datapath and in other sequential arithmetic blocks.

---
 rtl/pipo_shift_reg.sv | 79 +++++++
 tb/tb_pipo_shift_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipo_shift_reg.sv
// pipo_shift_reg: parallel-load register with a multi-cycle SRA/SRL/SLL/ROR shift engine and start/busy/done handshake.
module pipo_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  input  logic             sin,
  output logic [WIDTH-1:0] D,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  logic [WIDTH-1:0] d_q, d_d, shift_val;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             sout_q, sout_d, busy_q, busy_d, done_q, done_d, shift_out;
  // sin is only selected in SRL/SLL so it cannot leak into D from other modes
  always_comb begin
    shift_val = mode_q == 2'b00 ? {d_q[WIDTH-1], d_q[WIDTH-1:1]} :
                mode_q == 2'b01 ? {sin, d_q[WIDTH-1:1]} :
                mode_q == 2'b10 ? {d_q[WIDTH-2:0], sin} :
                                  {d_q[0], d_q[WIDTH-1:1]};
    shift_out = mode_q == 2'b10 ? d_q[WIDTH-1] : d_q[0];
  end
  always_comb begin
    d_d    = d_q;
    sout_d = sout_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (busy_q) begin
      d_d    = shift_val;
      sout_d = shift_out;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (ld) begin
      d_d = A;
    end else if (start) begin
      mode_d = mode;
      if (shamt == '0) begin
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        cnt_d  = shamt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= '0;
      sout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= 2'b00;
    end else begin
      d_q    <= d_d;
      sout_q <= sout_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end
  assign D    = d_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_pipo_shift_reg.sv
// tb_pipo_shift_reg: directed-vector bench for pipo_shift_reg with immediate assertions.
module tb_pipo_shift_reg;
  logic       clk = 1'b0;
  logic       reset, ld, start, sin;
  logic [7:0] A;
  logic [1:0] mode;
  logic [3:0] shamt;
  logic [7:0] D;
  logic       sout, busy, done;
  int n_chk = 0;
  int n_fail = 0;
  int bcyc, dcyc;
  pipo_shift_reg dut (
    .clk(clk), .reset(reset), .ld(ld), .A(A), .mode(mode), .start(start),
    .shamt(shamt), .sin(sin), .D(D), .sout(sout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [7:0] v);
    ld = 1'b1;
    A = v;
    step();
    ld = 1'b0;
    A = 8'h00;
  endtask
  // Pulse start, then wait (bounded) for done while counting busy cycles.
  task automatic shift(input logic [1:0] m, input logic [3:0] n, output int bc);
    logic seen;
    mode = m;
    shamt = n;
    start = 1'b1;
    step();
    start = 1'b0;
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      step();
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    chk("done_not_busy", {31'b0, busy}, 32'd0);
  endtask
  initial begin
    reset = 1'b1; ld = 1'b0; start = 1'b0; sin = 1'b0;
    A = 8'h00; mode = 2'b00; shamt = 4'd0;
    @(negedge clk);
    step();
    chk("rst_D", {24'b0, D}, 32'h00);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sout", {31'b0, sout}, 32'd0);
    reset = 1'b0;
    load(8'h5A);
    for (int i = 0; i < 5; i++) step();
    chk("hold_D", {24'b0, D}, 32'h5A);
    chk("hold_busy", {31'b0, busy}, 32'd0);
    chk("hold_done", {31'b0, done}, 32'd0);
    chk("hold_sout", {31'b0, sout}, 32'd0);
    load(8'b1001_0110);
    shift(2'b00, 4'd3, bcyc);
    chk("sra_D", {24'b0, D}, 32'hF2);
    chk("sra_sout", {31'b0, sout}, 32'd1);
    chk("sra_busy_cycles", bcyc, 32'd3);
    step();
    chk("sra_done_pulse", {31'b0, done}, 32'd0);
    sin = 1'b1;
    load(8'h03);
    shift(2'b10, 4'd2, bcyc);
    chk("sll_D", {24'b0, D}, 32'h0F);
    chk("sll_sout", {31'b0, sout}, 32'd0);
    chk("sll_busy_cycles", bcyc, 32'd2);
    sin = 1'b0;
    load(8'h80);
    shift(2'b01, 4'd7, bcyc);
    chk("srl_D", {24'b0, D}, 32'h01);
    chk("srl_sout", {31'b0, sout}, 32'd0);
    chk("srl_busy_cycles", bcyc, 32'd7);
    load(8'hA5);
    mode = 2'b11;
    shamt = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    bcyc = 0;
    dcyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        dcyc = 1;
        break;
      end
      if (busy) bcyc++;
      if (i == 2) begin
        mode = 2'b00; ld = 1'b1; A = 8'hFF; start = 1'b1; shamt = 4'd1;
      end
      if (i == 5) begin
        ld = 1'b0; start = 1'b0;
      end
      step();
    end
    chk("ror_done_seen", dcyc, 32'd1);
    chk("ror_D", {24'b0, D}, 32'hA5);
    chk("ror_sout", {31'b0, sout}, 32'd1);
    chk("ror_busy_cycles", bcyc, 32'd8);
    step();
    shamt = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_busy", {31'b0, busy}, 32'd0);
    chk("zero_D", {24'b0, D}, 32'hA5);
    step();
    chk("zero_done_drop", {31'b0, done}, 32'd0);
    load(8'b1001_0110);
    mode = 2'b00;
    shamt = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    chk("mid_D", {24'b0, D}, 32'hCB);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_D", {24'b0, D}, 32'h00);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_sout", {31'b0, sout}, 32'd0);
    dcyc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) dcyc++;
    end
    chk("abort_quiet", dcyc, 32'd0);
    sin = 1'b1;
    load(8'h81);
    shift(2'b01, 4'd1, bcyc);
    chk("post_D", {24'b0, D}, 32'hC0);
    chk("post_sout", {31'b0, sout}, 32'd1);
    chk("post_busy_cycles", bcyc, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
